// File: rtl/alu_muldiv_seq.sv
// Iterative 64-bit unsigned multiply/divide sequencer that borrows the integer ALU's adder.
// Shift-add multiply and restoring divide, one ALU add/subtract per cycle for 64 cycles.
module alu_muldiv_seq (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_op_i,
    input  logic [63:0] req_a_i,
    input  logic [63:0] req_b_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rsp_data_o,
    output logic [63:0] alu_a_o,
    output logic [63:0] alu_b_o,
    output logic        alu_cflag_o,
    output logic        alu_sum_en_o,
    output logic        alu_invb_en_o,
    input  logic [63:0] alu_out_i,
    input  logic        alu_cflag_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] mq_q, mq_d;
    logic [63:0] opnd_q, opnd_d;     // multiplicand for MUL*, divisor for DIV*
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] rsp_data_q, rsp_data_d;

    logic        is_div_s;
    logic [63:0] trial_s;
    logic        qbit_s;

    assign is_div_s = op_q[1];
    assign trial_s  = {acc_q[62:0], mq_q[63]};
    // A bit lost off the top of acc means the true trial exceeds any 64-bit divisor.
    assign qbit_s   = alu_cflag_i | acc_q[63];

    assign req_ready_o = (state_q == S_IDLE);
    assign rsp_valid_o = (state_q == S_DONE);
    assign rsp_data_o  = rsp_data_q;

    // ALU operand/control drive, only while iterating
    always_comb begin
        alu_a_o       = 64'd0;
        alu_b_o       = 64'd0;
        alu_cflag_o   = 1'b0;
        alu_sum_en_o  = 1'b0;
        alu_invb_en_o = 1'b0;
        if (state_q == S_RUN) begin
            alu_sum_en_o = 1'b1;
            if (is_div_s) begin
                alu_a_o       = trial_s;
                alu_b_o       = opnd_q;
                alu_cflag_o   = 1'b1;
                alu_invb_en_o = 1'b1;
            end else begin
                alu_a_o = acc_q;
                alu_b_o = mq_q[0] ? opnd_q : 64'd0;
            end
        end else begin
            alu_sum_en_o = 1'b0;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        acc_d      = acc_q;
        mq_d       = mq_q;
        opnd_d     = opnd_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    op_d    = req_op_i;
                    acc_d   = 64'd0;
                    mq_d    = req_op_i[1] ? req_a_i : req_b_i;
                    opnd_d  = req_op_i[1] ? req_b_i : req_a_i;
                    cnt_d   = 6'd63;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (is_div_s) begin
                    acc_d = qbit_s ? alu_out_i : trial_s;
                    mq_d  = {mq_q[62:0], qbit_s};
                end else begin
                    acc_d = {alu_cflag_i, alu_out_i[63:1]};
                    mq_d  = {alu_out_i[0], mq_q[63:1]};
                end
                if (cnt_q == 6'd0) begin
                    state_d    = S_DONE;
                    rsp_data_d = op_q[0] ? acc_d : mq_d;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            S_DONE: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            op_q       <= 2'd0;
            acc_q      <= 64'd0;
            mq_q       <= 64'd0;
            opnd_q     <= 64'd0;
            cnt_q      <= 6'd0;
            rsp_data_q <= 64'd0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            mq_q       <= mq_d;
            opnd_q     <= opnd_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
        end
    end

endmodule
